// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad scanner: rotates an active-low column strobe, debounces a
// single-row closure, and emits one KeyValid pulse per accepted press.
module keypad_scan_debounce #(
  parameter int SCAN_CYCLES     = 6000,
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic [3:0] Rows,
  output logic [3:0] Cols,
  output logic [3:0] KeyCode,
  output logic       KeyValid,
  output logic       KeyHeld,
  output logic [1:0] o_dbg_state
);

  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] SCAN       = 2'd0;
  localparam logic [1:0] DEBOUNCE   = 2'd1;
  localparam logic [1:0] HELD       = 2'd2;
  localparam logic [1:0] RELEASE_DB = 2'd3;

  logic [1:0]    r_state;
  logic [SW-1:0] r_scan_cnt;
  logic [DW-1:0] r_db_cnt;
  logic [1:0]    r_row;
  logic [1:0]    r_col;
  logic [3:0]    r_cols;
  logic [3:0]    r_key_code;
  logic          r_key_valid;
  logic          r_key_held;

  logic          w_one_low;
  logic [1:0]    w_low_idx;
  logic          w_match;
  logic [3:0]    w_next_cols;
  logic [3:0]    w_key_code;

  // Only a single low row is a usable closure; none or several are ignored.
  always_comb begin
    w_one_low = 1'b1;
    w_low_idx = 2'd0;
    case (Rows)
      4'b1110: w_low_idx = 2'd0;
      4'b1101: w_low_idx = 2'd1;
      4'b1011: w_low_idx = 2'd2;
      4'b0111: w_low_idx = 2'd3;
      default: w_one_low = 1'b0;
    endcase
  end

  assign w_match     = (Rows == ~(4'b0001 << r_row));
  assign w_next_cols = {r_cols[2:0], r_cols[3]};

  always_comb begin
    w_key_code = 4'h0;
    case ({r_row, r_col})
      4'b00_00: w_key_code = 4'h1;
      4'b00_01: w_key_code = 4'h2;
      4'b00_10: w_key_code = 4'h3;
      4'b00_11: w_key_code = 4'hA;
      4'b01_00: w_key_code = 4'h4;
      4'b01_01: w_key_code = 4'h5;
      4'b01_10: w_key_code = 4'h6;
      4'b01_11: w_key_code = 4'hB;
      4'b10_00: w_key_code = 4'h7;
      4'b10_01: w_key_code = 4'h8;
      4'b10_10: w_key_code = 4'h9;
      4'b10_11: w_key_code = 4'hC;
      4'b11_00: w_key_code = 4'hE;
      4'b11_01: w_key_code = 4'h0;
      4'b11_10: w_key_code = 4'hF;
      default:  w_key_code = 4'hD;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state     <= SCAN;
      r_scan_cnt  <= '0;
      r_db_cnt    <= '0;
      r_row       <= 2'd0;
      r_col       <= 2'd0;
      r_cols      <= 4'b1110;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      case (r_state)
        SCAN: begin
          if (w_one_low) begin
            r_row    <= w_low_idx;
            r_db_cnt <= '0;
            r_state  <= DEBOUNCE;
          end else if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= '0;
            r_col      <= r_col + 2'd1;
            r_cols     <= w_next_cols;
          end else begin
            r_scan_cnt <= r_scan_cnt + SW'(1);
          end
        end
        DEBOUNCE: begin
          if (!w_match) begin
            r_state    <= SCAN;
            r_scan_cnt <= '0;
            r_col      <= r_col + 2'd1;
            r_cols     <= w_next_cols;
          end else if (r_db_cnt == DB_LAST) begin
            r_state     <= HELD;
            r_key_valid <= 1'b1;
            r_key_code  <= w_key_code;
            r_key_held  <= 1'b1;
          end else begin
            r_db_cnt <= r_db_cnt + DW'(1);
          end
        end
        HELD: begin
          if (Rows[r_row]) begin
            r_db_cnt <= '0;
            r_state  <= RELEASE_DB;
          end
        end
        RELEASE_DB: begin
          // A brief re-closure of the latched row counts as still held.
          if (!Rows[r_row]) begin
            r_state <= HELD;
          end else if (r_db_cnt == DB_LAST) begin
            r_state    <= SCAN;
            r_key_held <= 1'b0;
            r_scan_cnt <= '0;
            r_col      <= r_col + 2'd1;
            r_cols     <= w_next_cols;
          end else begin
            r_db_cnt <= r_db_cnt + DW'(1);
          end
        end
        default: r_state <= SCAN;
      endcase
    end
  end

  assign Cols        = r_cols;
  assign KeyCode     = r_key_code;
  assign KeyValid    = r_key_valid;
  assign KeyHeld     = r_key_held;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: a virtual keypad matrix drives Rows from the
// pressed-key set, and an abstract run-length model predicts every output.
module tb_keypad_scan_debounce;

  localparam int SCAN = 4;
  localparam int DEB  = 8;

  logic       clk = 1'b0;
  logic       Reset = 1'b0;
  logic [3:0] Rows = 4'hF;
  logic [3:0] Cols;
  logic [3:0] KeyCode;
  logic       KeyValid;
  logic       KeyHeld;
  logic [1:0] dbg_state;

  keypad_scan_debounce #(.SCAN_CYCLES(SCAN), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .Reset(Reset), .Rows(Rows), .Cols(Cols), .KeyCode(KeyCode),
    .KeyValid(KeyValid), .KeyHeld(KeyHeld), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Pressed keys, bit index = row*4 + col.
  logic [15:0] pressed = 16'h0;
  int          pulses;
  logic [3:0]  last_code;

  // Model: mode 0 scanning, 1 confirming, 2 holding, 3 confirming release.
  int         m_mode, m_col, m_dwell, m_run, m_row;
  logic [3:0] m_code;
  logic       m_valid, m_held;

  task automatic check_eq(input string tag, input logic [7:0] obs,
                          input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] key_of(input int r, input int c);
    string map = "123A456B789CE0FD";
    byte   ch;
    ch = map[r*4 + c];
    if (ch <= 8'h39) return 4'(ch - 8'h30);
    return 4'(ch - 8'h41 + 10);
  endfunction

  function automatic logic [3:0] model_cols();
    logic [3:0] c = 4'b1111;
    c[m_col] = 1'b0;
    return c;
  endfunction

  function automatic logic [3:0] keypad_rows(input int col, input logic [15:0] p);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = ~p[i*4 + col];
    return r;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_col = 0; m_dwell = 0; m_run = 0; m_row = 0;
    m_code = 4'h0; m_valid = 1'b0; m_held = 1'b0;
  endtask

  task automatic model_next_col();
    m_col = (m_col + 1) % 4;
    m_dwell = 0;
  endtask

  task automatic model_step(input logic [3:0] r);
    int lows;
    int idx;
    logic [3:0] want;
    m_valid = 1'b0;
    want = 4'b1111;
    want[m_row] = 1'b0;
    case (m_mode)
      0: begin
        lows = 0; idx = 0;
        for (int i = 0; i < 4; i++) if (!r[i]) begin lows++; idx = i; end
        if (lows == 1) begin
          m_row = idx; m_run = 0; m_mode = 1;
        end else begin
          m_dwell++;
          if (m_dwell == SCAN) model_next_col();
        end
      end
      1: begin
        if (r != want) begin
          m_mode = 0; model_next_col();
        end else if (m_run == DEB - 1) begin
          m_mode = 2; m_valid = 1'b1; m_held = 1'b1;
          m_code = key_of(m_row, m_col);
        end else m_run++;
      end
      2: if (r[m_row]) begin m_mode = 3; m_run = 0; end
      default: begin
        if (!r[m_row]) m_mode = 2;
        else if (m_run == DEB - 1) begin
          m_mode = 0; m_held = 1'b0; model_next_col();
        end else m_run++;
      end
    endcase
  endtask

  // One clock: drive Rows from the keypad, advance model, compare at negedge.
  task automatic tick();
    Rows = keypad_rows(m_col, pressed);
    @(posedge clk);
    if (Reset) model_step(Rows);
    @(negedge clk);
    check_eq("cols", Cols, model_cols());
    check_eq("code", KeyCode, m_code);
    check_eq("valid", KeyValid, m_valid);
    check_eq("held", KeyHeld, m_held);
    if (KeyValid === 1'b1) begin pulses++; last_code = KeyCode; end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_reset_now(input string tag);
    check_eq({tag, "_cols"}, Cols, 4'b1110);
    check_eq({tag, "_code"}, KeyCode, 4'h0);
    check_eq({tag, "_valid"}, KeyValid, 1'b0);
    check_eq({tag, "_held"}, KeyHeld, 1'b0);
  endtask

  // Assert reset asynchronously mid-cycle, hold n cycles, then release.
  task automatic do_reset(input int n);
    Reset = 1'b0;
    #1;
    model_reset();
    check_reset_now("rst_async");
    ticks(n);
    Reset = 1'b1;
  endtask

  task automatic wait_model(input int mode, input int run, input int limit);
    int k = 0;
    while (!(m_mode == mode && (run < 0 || m_run == run)) && k < limit) begin
      tick();
      k++;
    end
    if (k >= limit) begin
      n_vec++; n_err++;
      $display("FAIL wait_timeout: mode %0d run %0d not reached in %0d cycles",
               mode, run, limit);
    end
  endtask

  task automatic expect_events(input string tag, input int n, input logic [3:0] code);
    check_eq({tag, "_pulses"}, 8'(pulses), 8'(n));
    if (n > 0) check_eq({tag, "_code"}, last_code, code);
    pulses = 0;
  endtask

  initial begin
    int key, hold, k;
    model_reset();
    pulses = 0;
    last_code = 4'h0;
    @(negedge clk);
    check_reset_now("rst_hold");
    ticks(3);
    Reset = 1'b1;

    // 1: idle rotation
    ticks(20);
    expect_events("idle", 0, 4'h0);

    // 2: clean press of 5 (r1 c1)
    pressed = 16'h1 << 5;
    ticks(40);
    pressed = 16'h0;
    ticks(30);
    expect_events("press5", 1, 4'h5);

    // 3: bounce on D (r3 c3) then stable hold
    wait_model(0, -1, 10);
    k = 0;
    while (!(m_col == 3 && m_dwell == 0) && k < 40) begin tick(); k++; end
    for (int b = 0; b < 3; b++) begin
      pressed = 16'h1 << 15; ticks(3);
      pressed = 16'h0;       ticks(1);
    end
    pressed = 16'h1 << 15;
    ticks(20);
    pressed = 16'h0;
    ticks(30);
    expect_events("bounceD", 1, 4'hD);

    // 4: hold 1 (r0 c0) with rollover onto row 1 in the same column
    pressed = 16'h1;
    wait_model(2, -1, 40);
    pressed = 16'h1 | (16'h1 << 4);
    ticks(10);
    pressed = 16'h0;
    ticks(20);
    expect_events("roll1", 1, 4'h1);

    // 5: release bounce on 9 (r2 c2)
    pressed = 16'h1 << 10;
    wait_model(2, -1, 40);
    ticks(3);
    pressed = 16'h0;
    wait_model(3, 5, 20);
    pressed = 16'h1 << 10;
    ticks(1);
    pressed = 16'h0;
    ticks(30);
    expect_events("relb9", 1, 4'h9);

    // 6a: two rows closed in one column never detect
    pressed = 16'h1 | (16'h1 << 4);
    ticks(24);
    pressed = 16'h0;
    expect_events("multirow", 0, 4'h0);

    // 6b: reset mid-debounce with 8 (r2 c1) held through it
    pressed = 16'h1 << 9;
    wait_model(1, 4, 40);
    do_reset(2);
    ticks(40);
    pressed = 16'h0;
    ticks(30);
    expect_events("rst8", 1, 4'h8);

    // Randomized presses, bounces, rollover and occasional resets.
    for (int it = 0; it < 40; it++) begin
      key = $urandom_range(0, 15);
      for (int b = 0; b < int'($urandom_range(0, 3)); b++) begin
        pressed = 16'h1 << key; ticks($urandom_range(1, 4));
        pressed = 16'h0;        ticks(1);
      end
      pressed = 16'h1 << key;
      hold = $urandom_range(0, 40);
      ticks(hold);
      if ($urandom_range(0, 3) == 0) begin
        pressed = pressed | (16'h1 << $urandom_range(0, 15));
        ticks($urandom_range(1, 10));
      end
      if ($urandom_range(0, 9) == 0) do_reset($urandom_range(1, 3));
      pressed = 16'h0;
      ticks($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        pressed = 16'h1 << key; ticks(1); pressed = 16'h0;
      end
      ticks($urandom_range(10, 30));
    end
    pulses = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
